// File: rtl/blit_pkg.sv
// Shared types for the blitter memory arbiter.
//   arb_state_t : arbiter sequencer states
//   wr_entry_t  : one merged word write held in the write FIFO
package blit_pkg;

    localparam int unsigned ADDR_W = 26;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned WORD_W = ADDR_W - 2;

    typedef enum logic [1:0] {
        IDLE,
        WR_ISSUE,
        RD_ISSUE,
        RD_WAIT
    } arb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:2] addr;
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   be;
    } wr_entry_t;

    // Word index back to a word-aligned byte address.
    function automatic logic [ADDR_W-1:0] word_to_byte(input logic [WORD_W-1:0] word);
        return {word, 2'b00};
    endfunction

endpackage

// File: rtl/blit_wr_fifo.sv
// Write FIFO for merged blitter words.
//   clock, reset_n : clock, asynchronous active-low reset (flushes the FIFO)
//   push, push_entry : enqueue request and payload
//   pop            : dequeue the head entry
//   match_addr     : word address compared against every valid entry
//   count, head    : occupancy and oldest entry
//   match          : per-slot hit of a valid entry against match_addr
//   empty          : no entries held
//   drop_c         : a push was refused because the FIFO was full
module blit_wr_fifo
    import blit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  wr_entry_t                push_entry,
    input  logic                     pop,
    input  logic [WORD_W-1:0]        match_addr,
    output logic [$clog2(DEPTH):0]   count,
    output wr_entry_t                head,
    output logic [DEPTH-1:0]         match,
    output logic                     empty,
    output logic                     drop_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [DEPTH-1:0] valid_q;
    wr_entry_t        mem_q [DEPTH];

    logic          full;
    logic          pop_ok;
    logic          push_ok;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];
    assign count  = wr_ptr - rd_ptr;
    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign head   = mem_q[rd_idx];

    // A pop in the same cycle frees the slot, so a push at full is still taken.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign drop_c  = push && full && !pop_ok;

    // Pointer and slot-valid bookkeeping; push/pop at full share a slot, push wins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            valid_q <= '0;
        end else begin
            if (pop_ok) begin
                rd_ptr          <= rd_ptr + CW'(1);
                valid_q[rd_idx] <= 1'b0;
            end
            if (push_ok) begin
                wr_ptr          <= wr_ptr + CW'(1);
                valid_q[wr_idx] <= 1'b1;
            end
        end
    end

    // Payload storage; contents are don't-care until their slot is valid.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_idx] <= push_entry;
        end
    end

    // Read-after-write hazard detection against every queued write.
    always_comb begin
        match = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            match[i] = valid_q[i] && (mem_q[i].addr == match_addr);
        end
    end

endmodule

// File: rtl/blit_mem_arb.sv
// Arbiter/sequencer for the blitter's single memory port.
//   clock, reset_n            : clock, asynchronous active-low reset
//   p5_*                      : merged word writes from the byte-merge stage
//   rd_req/rd_addr/rd_ack     : single-word source read request handshake
//   rd_data/rd_valid          : read return to the fetch stage
//   blit_stall, idle          : pipeline back-pressure and quiescence status
//   err_overflow              : sticky flag for a write dropped at full FIFO
//   mem_*                     : valid/ready memory request port and read return
module blit_mem_arb
    import blit_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned STALL_LEVEL = 2,
    parameter int unsigned HIGH_WATER  = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] p5_addr,
    input  logic [DATA_W-1:0] p5_data,
    input  logic [BE_W-1:0]   p5_byte_enable,
    input  logic              p5_write,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              blit_stall,
    output logic              idle,
    output logic              err_overflow,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BE_W-1:0]   mem_byte_enable,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid
);

    localparam int unsigned    CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]  STALL_CNT = CW'(STALL_LEVEL);
    localparam logic [CW-1:0]  HIGH_CNT  = CW'(HIGH_WATER);

    arb_state_t            state;
    logic                  run_q;
    logic [CW-1:0]         fifo_count;
    wr_entry_t             fifo_head;
    wr_entry_t             push_entry;
    logic [FIFO_DEPTH-1:0] addr_match;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic                  fifo_drop;
    logic                  hazard;
    logic                  read_ok;
    logic                  high_water;
    logic                  pick_wr;
    logic                  pick_rd;
    logic                  unused_lsbs;

    // Byte offsets are meaningless on a word port.
    assign unused_lsbs = ^{p5_addr[1:0], rd_addr[1:0]};

    assign push_entry = '{addr: p5_addr[ADDR_W-1:2], data: p5_data, be: p5_byte_enable};
    assign fifo_pop   = (state == WR_ISSUE) && mem_ready;

    blit_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (p5_write),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .match_addr (rd_addr[ADDR_W-1:2]),
        .count      (fifo_count),
        .head       (fifo_head),
        .match      (addr_match),
        .empty      (fifo_empty),
        .drop_c     (fifo_drop)
    );

    // Arbitration: high water forces writes, else a hazard-free read, else drain.
    assign hazard     = |addr_match;
    assign read_ok    = rd_req && !hazard;
    assign high_water = (fifo_count >= HIGH_CNT);
    assign pick_wr    = high_water || (!read_ok && !fifo_empty);
    assign pick_rd    = !high_water && read_ok;

    // Sequencer; memory request fields are latched at the IDLE decision and held.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            run_q           <= 1'b0;
            err_overflow    <= 1'b0;
            mem_valid       <= 1'b0;
            mem_write       <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            mem_byte_enable <= '0;
        end else begin
            run_q <= 1'b1;
            if (fifo_drop) begin
                err_overflow <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pick_wr) begin
                        state           <= WR_ISSUE;
                        mem_valid       <= 1'b1;
                        mem_write       <= 1'b1;
                        mem_addr        <= word_to_byte(fifo_head.addr);
                        mem_wdata       <= fifo_head.data;
                        mem_byte_enable <= fifo_head.be;
                    end else if (pick_rd) begin
                        state           <= RD_ISSUE;
                        mem_valid       <= 1'b1;
                        mem_write       <= 1'b0;
                        mem_addr        <= word_to_byte(rd_addr[ADDR_W-1:2]);
                        mem_wdata       <= '0;
                        mem_byte_enable <= '1;
                    end
                end
                WR_ISSUE: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                RD_ISSUE: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        state     <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (mem_rvalid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake pulses follow the memory port in the same cycle.
    assign rd_ack     = (state == RD_ISSUE) && mem_ready;
    assign rd_valid   = (state == RD_WAIT) && mem_rvalid;
    assign rd_data    = rd_valid ? mem_rdata : '0;
    assign blit_stall = (fifo_count >= STALL_CNT);
    // run_q keeps idle low while held in reset.
    assign idle       = run_q && (state == IDLE) && fifo_empty && !rd_req;

endmodule
